// File: rtl/frac_pkg.sv
// Shared constants, id-width helper and the tag-pipe entry type for frac_sched.
package frac_pkg;

  localparam int unsigned FRAC_LAT = 4;
  localparam int unsigned FRAC_N   = 16;
  localparam int unsigned TAG_ID_W = 3;

  // Requester id width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

  // One tag-pipe entry: operand valid plus owning requester id (sized for NREQ up to 8).
  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
module rr_arbiter
  import frac_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant_c,
  output logic [IW-1:0]   o_idx_c,
  output logic            o_any_c
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  // Scan NREQ positions starting at the pointer and keep the first hit.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IW'((32'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found   = 1'b1;
        o_any_c   = 1'b1;
        o_idx_c   = w_cand;
        o_grant_c = NREQ'(1) << w_cand;
      end
    end
  end

endmodule

// File: rtl/frac_sched.sv
// Round-robin sharing of one float-to-fixed converter among NREQ requesters,
// with id tracking through the converter pipeline and result backpressure.
module frac_sched
  import frac_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned N    = FRAC_N,
  parameter  int unsigned LAT  = FRAC_LAT,
  localparam int unsigned IW   = id_width(NREQ)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [32*NREQ-1:0]   i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_conv_enable,
  output logic                 o_conv_input_valid,
  output logic [31:0]          o_conv_num,
  input  logic                 i_conv_output_valid,
  input  logic [N-1:0]         i_conv_fixed,
  output logic                 o_res_valid,
  output logic [N-1:0]         o_res_data,
  output logic [IW-1:0]        o_res_id,
  input  logic                 i_res_ready,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int unsigned CW = $clog2(LAT + 1);

  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  tag_t            r_tag [LAT];
  logic            r_err;

  logic            w_stall;
  logic            w_any_req;
  logic            w_busy;
  logic            w_en;
  logic            w_grant;
  logic            w_accept;
  logic            w_arb_any;
  logic [NREQ-1:0] w_arb_onehot;
  logic [IW-1:0]   w_arb_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req     (i_req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_arb_onehot),
    .o_idx_c   (w_arb_idx),
    .o_any_c   (w_arb_any)
  );

  // Enable gating: freeze on a stalled result, idle when nothing is pending; held off in reset.
  assign w_stall   = i_conv_output_valid & ~i_res_ready;
  assign w_any_req = |i_req_valid;
  assign w_busy    = (r_count != '0);
  assign w_en      = resetn & ~w_stall & (w_busy | w_any_req);
  assign w_grant   = w_en & w_arb_any;
  assign w_accept  = i_conv_output_valid & i_res_ready;

  assign o_conv_enable      = w_en;
  assign o_conv_input_valid = w_grant;
  assign o_req_ready        = w_grant ? w_arb_onehot : '0;
  assign o_conv_num         = w_grant ? i_req_data[32*w_arb_idx +: 32] : 32'h0;

  assign o_res_valid = i_conv_output_valid;
  assign o_res_data  = i_conv_fixed;
  assign o_res_id    = r_tag[LAT-1].id[IW-1:0];
  assign o_busy      = w_busy;
  assign o_err       = r_err;

  // Round-robin pointer moves just past the last granted requester.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_arb_idx == IW'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
    end
  end

  // Tag pipe mirrors the converter: advances only on enabled edges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else if (w_en) begin
      r_tag[0] <= {w_grant, TAG_ID_W'(w_arb_idx)};
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // In-flight count: up on grant, down on accepted result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (w_grant && !w_accept) begin
      r_count <= r_count + 1'b1;
    end else if (!w_grant && w_accept) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Sticky flag when the converter valid and the tracked valid disagree.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (w_en && (i_conv_output_valid != r_tag[LAT-1].v)) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frac_sched.sv
// Bench for frac_sched: behavioural converter, queue-based reference model, directed + random stimulus.
module tb_frac_sched;
  import frac_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned N    = 16;
  localparam int unsigned LAT  = 4;
  localparam int unsigned IW   = 2;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                conv_enable;
  logic                conv_input_valid;
  logic [31:0]         conv_num;
  logic                conv_output_valid;
  logic [N-1:0]        conv_fixed;
  logic                res_valid;
  logic [N-1:0]        res_data;
  logic [IW-1:0]       res_id;
  logic                res_ready;
  logic                busy;
  logic                err;

  frac_sched #(.NREQ(NREQ), .N(N), .LAT(LAT)) dut (
    .clock              (clock),
    .resetn             (resetn),
    .i_req_valid        (req_valid),
    .i_req_data         (req_data),
    .o_req_ready        (req_ready),
    .o_conv_enable      (conv_enable),
    .o_conv_input_valid (conv_input_valid),
    .o_conv_num         (conv_num),
    .i_conv_output_valid(conv_output_valid),
    .i_conv_fixed       (conv_fixed),
    .o_res_valid        (res_valid),
    .o_res_data         (res_data),
    .o_res_id           (res_id),
    .i_res_ready        (res_ready),
    .o_busy             (busy),
    .o_err              (err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Float to unsigned Q0.16, truncating; negatives and denormals give 0.
  function automatic logic [15:0] f2x(input logic [31:0] f);
    logic [63:0] m;
    int          sh;
    if (f[31] || f[30:23] == 8'd0) return 16'h0;
    m  = {40'h0, 1'b1, f[22:0]};
    sh = int'(f[30:23]) - 134;
    if (sh >= 16) return 16'h0;
    if (sh >= 0) m = m << sh;
    else if (sh <= -24) m = 64'h0;
    else m = m >> (-sh);
    return m[15:0];
  endfunction

  // Behavioural converter: LAT-stage pipe advanced by conv_enable, reset by resetn.
  logic        cv_v [LAT];
  logic [15:0] cv_d [LAT];
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) begin cv_v[i] <= 1'b0; cv_d[i] <= 16'h0; end
    end else if (conv_enable) begin
      cv_v[0] <= conv_input_valid;
      cv_d[0] <= conv_input_valid ? f2x(conv_num) : 16'h0;
      for (int i = 1; i < LAT; i++) begin cv_v[i] <= cv_v[i-1]; cv_d[i] <= cv_d[i-1]; end
    end
  end
  assign conv_output_valid = cv_v[LAT-1];
  assign conv_fixed        = cv_d[LAT-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model state: in-flight results in issue order, plus logs for directed tests.
  int          q_id[$];
  logic [15:0] q_d[$];
  int          mp = 0;
  int          gnt_log[$];
  int          res_log[$];
  int          res_cyc[$];
  logic [15:0] res_dat[$];
  int          res_count = 0;

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Monitor: compares every cycle against the model, mid-cycle away from the clock edge.
  always @(negedge clock) begin
    bit any;
    bit st;
    bit en_exp;
    int g;
    if (res_valid && res_ready) res_count++;
    if (!resetn) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_conv_enable", 64'(conv_enable), 64'(0));
      chk("rst_conv_ivalid", 64'(conv_input_valid), 64'(0));
      chk("rst_conv_num", 64'(conv_num), 64'(0));
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_res_data", 64'(res_data), 64'(0));
      chk("rst_res_id", 64'(res_id), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      q_id.delete();
      q_d.delete();
      mp = 0;
    end else begin
      any    = |req_valid;
      st     = conv_output_valid && !res_ready;
      en_exp = !st && (q_id.size() != 0 || any);
      chk("conv_enable", 64'(conv_enable), 64'(en_exp));
      chk("busy", 64'(busy), 64'(q_id.size() != 0));
      chk("err", 64'(err), 64'(0));
      chk("res_valid", 64'(res_valid), 64'(conv_output_valid));
      if (conv_output_valid) begin
        if (q_id.size() == 0) begin
          chk("res_unexpected", 64'(1), 64'(0));
        end else begin
          chk("res_id", 64'(res_id), 64'(q_id[0]));
          chk("res_data", 64'(res_data), 64'(q_d[0]));
          if (res_ready) begin
            res_log.push_back(q_id.pop_front());
            res_dat.push_back(q_d.pop_front());
            res_cyc.push_back(cyc);
          end
        end
      end
      if (en_exp && any) begin
        g = rr_pick(mp, req_valid);
        chk("req_ready", 64'(req_ready), 64'(1) << g);
        chk("conv_ivalid", 64'(conv_input_valid), 64'(1));
        chk("conv_num", 64'(conv_num), 64'(req_data[32*g +: 32]));
        q_id.push_back(g);
        q_d.push_back(f2x(req_data[32*g +: 32]));
        gnt_log.push_back(g);
        mp = (g + 1) % NREQ;
      end else begin
        chk("req_ready_idle", 64'(req_ready), 64'(0));
        chk("conv_ivalid_idle", 64'(conv_input_valid), 64'(0));
        chk("conv_num_idle", 64'(conv_num), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); res_log.delete(); res_cyc.delete(); res_dat.delete();
  endtask

  task automatic drain();
    int k;
    k = 0;
    req_valid = '0;
    res_ready = 1'b1;
    while ((q_id.size() != 0 || busy) && k < 60) begin step(); k++; end
    chk("drain_timeout", 64'(k >= 60), 64'(0));
  endtask

  function automatic logic [31:0] rnd_float();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 134)), 23'($urandom)};
  endfunction

  initial begin
    int          t0;
    int          rc0;
    logic [15:0] hd;
    logic [IW-1:0] hid;

    // Reset with requests pending: outputs must stay at reset values.
    req_valid = '1;
    req_data  = {4{32'h3F800000}};
    res_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    req_valid = '0;
    resetn    = 1'b1;
    step();

    // Full contention from ptr 0.
    clear_logs();
    for (int j = 0; j < NREQ; j++) req_data[32*j +: 32] = rnd_float();
    t0 = cyc;
    req_valid = '1;
    repeat (8) step();
    drain();
    chk("fc_ngrant", 64'(gnt_log.size()), 64'(8));
    chk("fc_nres", 64'(res_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < res_log.size(); i++) begin
      chk("fc_gnt_order", 64'(gnt_log[i]), 64'(i % NREQ));
      chk("fc_res_id", 64'(res_log[i]), 64'(i % NREQ));
      chk("fc_res_cycle", 64'(res_cyc[i]), 64'(t0 + 4 + i));
    end

    // Single op from requester 2: 0.5 -> 0x8000 after LAT cycles, then idle.
    clear_logs();
    step();
    t0 = cyc;
    req_data[95:64] = 32'h3F000000;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (4) step();
    @(negedge clock);
    chk("single_idle_en", 64'(conv_enable), 64'(0));
    drain();
    chk("single_nres", 64'(res_log.size()), 64'(1));
    if (res_log.size() > 0) begin
      chk("single_cycle", 64'(res_cyc[0]), 64'(t0 + 4));
      chk("single_id", 64'(res_log[0]), 64'(2));
      chk("single_data", 64'(res_dat[0]), 64'(16'h8000));
    end

    // Fairness wrap: ptr now 3, requests 0 and 3.
    clear_logs();
    req_data[31:0]   = 32'h3E800000;
    req_data[127:96] = 32'h3F400000;
    req_valid = 4'b1001;
    step();
    step();
    drain();
    chk("wrap_ngrant", 64'(gnt_log.size()), 64'(2));
    if (gnt_log.size() >= 2) begin
      chk("wrap_first", 64'(gnt_log[0]), 64'(3));
      chk("wrap_second", 64'(gnt_log[1]), 64'(0));
    end

    // Negative operand truncates to zero.
    clear_logs();
    req_data[63:32] = 32'hBF800000;
    req_valid = 4'b0010;
    step();
    drain();
    chk("neg_nres", 64'(res_log.size()), 64'(1));
    if (res_log.size() > 0) begin
      chk("neg_id", 64'(res_log[0]), 64'(1));
      chk("neg_data", 64'(res_dat[0]), 64'(0));
    end

    // Backpressure: hold res_ready low for 3 cycles with the pipe full.
    clear_logs();
    for (int j = 0; j < NREQ; j++) req_data[32*j +: 32] = rnd_float();
    req_valid = '1;
    repeat (4) step();
    res_ready = 1'b0;
    @(negedge clock);
    hd  = res_data;
    hid = res_id;
    chk("bp_valid", 64'(res_valid), 64'(1));
    chk("bp_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clock);
      chk("bp_hold_data", 64'(res_data), 64'(hd));
      chk("bp_hold_id", 64'(res_id), 64'(hid));
      chk("bp_no_grant", 64'(req_ready), 64'(0));
    end
    step();
    res_ready = 1'b1;
    step();
    drain();
    chk("bp_ngrant", 64'(gnt_log.size()), 64'(5));
    chk("bp_nres", 64'(res_log.size()), 64'(5));
    for (int i = 0; i < res_log.size() && i < gnt_log.size(); i++)
      chk("bp_order", 64'(res_log[i]), 64'(gnt_log[i]));

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      for (int j = 0; j < NREQ; j++) req_data[32*j +: 32] = rnd_float();
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    chk("err_final", 64'(err), 64'(0));

    // Reset with three operands in flight: nothing may come out afterwards.
    req_valid = '1;
    res_ready = 1'b1;
    repeat (3) step();
    resetn = 1'b0;
    step();
    step();
    req_valid = '0;
    resetn = 1'b1;
    rc0 = res_count;
    repeat (12) step();
    chk("post_reset_res", 64'(res_count - rc0), 64'(0));
    chk("post_reset_busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
